// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer in front of data_memory: validates a load/store request,
// drives the memory port for a fixed window and returns the result to writeback.
module mem_access_ctrl #(
    parameter int unsigned MEM_BYTES   = 4096,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_datawr,
    output logic        mem_dmwr,
    output logic [2:0]  mem_dmctrl,
    input  logic [31:0] mem_datard,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;
    localparam logic [1:0] FAULT_CTRL  = 2'b11;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          lat_write;

    logic [2:0]  acc_size;
    logic [32:0] last_byte;
    logic        illegal_ctrl;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  fault;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_size = 3'd4;
        case (req_ctrl[1:0])
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
    end

    // Range check is done on 33 bits so an access near 0xFFFFFFFF cannot wrap to a small address.
    assign last_byte    = {1'b0, req_addr} + 33'(acc_size) - 33'd1;
    assign illegal_ctrl = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111);
    assign misaligned   = ((req_ctrl[1:0] == 2'b01) && req_addr[0])
                       || ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign out_of_range = (last_byte >= 33'(MEM_BYTES));

    always_comb begin
        fault = FAULT_OK;
        if (illegal_ctrl)      fault = FAULT_CTRL;
        else if (misaligned)   fault = FAULT_ALIGN;
        else if (out_of_range) fault = FAULT_RANGE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_write   <= 1'b0;
            mem_address <= '0;
            mem_datawr  <= '0;
            mem_dmwr    <= 1'b0;
            mem_dmctrl  <= 3'b010;
            rsp_rdata   <= '0;
            rsp_fault   <= FAULT_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (fault != FAULT_OK) begin
                            rsp_fault <= fault;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            mem_address <= req_addr;
                            mem_datawr  <= req_wdata;
                            mem_dmctrl  <= req_ctrl;
                            mem_dmwr    <= req_write;
                            lat_write   <= req_write;
                            cnt         <= CW'(MEM_LATENCY - 1);
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The write strobe lives only for the first window cycle: one pulse per store.
                    mem_dmwr <= 1'b0;
                    if (cnt == '0) begin
                        rsp_rdata <= lat_write ? 32'd0 : mem_datard;
                        rsp_fault <= FAULT_OK;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (MEM_LATENCY 1 and 3), each
// in front of a small behavioural data_memory model.
module tb_mem_access_ctrl;

    logic clk;
    logic rst_n;

    logic        req_valid_1, req_ready_1, req_write_1;
    logic [2:0]  req_ctrl_1;
    logic [31:0] req_addr_1, req_wdata_1;
    logic [31:0] mem_address_1, mem_datawr_1, mem_datard_1;
    logic        mem_dmwr_1;
    logic [2:0]  mem_dmctrl_1;
    logic        rsp_valid_1, rsp_ready_1;
    logic [31:0] rsp_rdata_1;
    logic [1:0]  rsp_fault_1;

    logic        req_valid_3, req_ready_3, req_write_3;
    logic [2:0]  req_ctrl_3;
    logic [31:0] req_addr_3, req_wdata_3;
    logic [31:0] mem_address_3, mem_datawr_3, mem_datard_3;
    logic        mem_dmwr_3;
    logic [2:0]  mem_dmctrl_3;
    logic        rsp_valid_3, rsp_ready_3;
    logic [31:0] rsp_rdata_3;
    logic [1:0]  rsp_fault_3;

    int n_checks = 0;
    int n_fail   = 0;
    int dmwr_cnt_1 = 0;
    int dmwr_cnt_3 = 0;

    logic [33:0] q1 [$];
    logic [33:0] q3 [$];

    logic [7:0] mem_1 [4096];
    logic [7:0] mem_3 [4096];

    mem_access_ctrl #(.MEM_BYTES(4096), .MEM_LATENCY(1)) dut_1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
        .req_ctrl(req_ctrl_1), .req_addr(req_addr_1), .req_wdata(req_wdata_1),
        .mem_address(mem_address_1), .mem_datawr(mem_datawr_1), .mem_dmwr(mem_dmwr_1),
        .mem_dmctrl(mem_dmctrl_1), .mem_datard(mem_datard_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_fault(rsp_fault_1)
    );

    mem_access_ctrl #(.MEM_BYTES(4096), .MEM_LATENCY(3)) dut_3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(req_write_3),
        .req_ctrl(req_ctrl_3), .req_addr(req_addr_3), .req_wdata(req_wdata_3),
        .mem_address(mem_address_3), .mem_datawr(mem_datawr_3), .mem_dmwr(mem_dmwr_3),
        .mem_dmctrl(mem_dmctrl_3), .mem_datard(mem_datard_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
        .rsp_rdata(rsp_rdata_3), .rsp_fault(rsp_fault_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] extend(input logic [2:0] c, input logic [31:0] w);
        case (c)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Little-endian byte memories: combinational read, write on the strobe at the clock edge.
    logic [11:0] a1, a3;
    assign a1 = mem_address_1[11:0];
    assign a3 = mem_address_3[11:0];

    always_comb mem_datard_1 = extend(mem_dmctrl_1,
        {mem_1[a1 + 12'd3], mem_1[a1 + 12'd2], mem_1[a1 + 12'd1], mem_1[a1]});
    always_comb mem_datard_3 = extend(mem_dmctrl_3,
        {mem_3[a3 + 12'd3], mem_3[a3 + 12'd2], mem_3[a3 + 12'd1], mem_3[a3]});

    always @(posedge clk) begin
        if (mem_dmwr_1) begin
            mem_1[a1] <= mem_datawr_1[7:0];
            if (mem_dmctrl_1[1:0] != 2'b00) mem_1[a1 + 12'd1] <= mem_datawr_1[15:8];
            if (mem_dmctrl_1[1]) begin
                mem_1[a1 + 12'd2] <= mem_datawr_1[23:16];
                mem_1[a1 + 12'd3] <= mem_datawr_1[31:24];
            end
        end
        if (mem_dmwr_3) begin
            mem_3[a3] <= mem_datawr_3[7:0];
            if (mem_dmctrl_3[1:0] != 2'b00) mem_3[a3 + 12'd1] <= mem_datawr_3[15:8];
            if (mem_dmctrl_3[1]) begin
                mem_3[a3 + 12'd2] <= mem_datawr_3[23:16];
                mem_3[a3 + 12'd3] <= mem_datawr_3[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a response handshake is presented.
    always @(negedge clk) begin
        if (mem_dmwr_1) dmwr_cnt_1++;
        if (mem_dmwr_3) dmwr_cnt_3++;
        if (rsp_valid_1 && rsp_ready_1) begin
            if (q1.size() == 0) begin
                check("rsp1 unexpected", 32'd1, 32'd0);
            end else begin
                logic [33:0] e1;
                e1 = q1.pop_front();
                check("rsp1 rdata", rsp_rdata_1, e1[33:2]);
                check("rsp1 fault", 32'(rsp_fault_1), 32'(e1[1:0]));
            end
        end
        if (rsp_valid_3 && rsp_ready_3) begin
            if (q3.size() == 0) begin
                check("rsp3 unexpected", 32'd1, 32'd0);
            end else begin
                logic [33:0] e3;
                e3 = q3.pop_front();
                check("rsp3 rdata", rsp_rdata_3, e3[33:2]);
                check("rsp3 fault", 32'(rsp_fault_3), 32'(e3[1:0]));
            end
        end
    end

    task automatic drive(input bit sel, input logic v, input logic w, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            req_valid_3 = v; req_write_3 = w; req_ctrl_3 = c; req_addr_3 = a; req_wdata_3 = d;
        end else begin
            req_valid_1 = v; req_write_1 = w; req_ctrl_1 = c; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // Issues one request, pushes its expected response and measures accept-to-rsp_valid latency.
    task automatic issue(input bit sel, input logic w, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] er, input logic [1:0] ef,
                         input int el, input string name);
        int lat;
        if (sel) q3.push_back({er, ef});
        else     q1.push_back({er, ef});
        @(posedge clk); #1;
        drive(sel, 1'b1, w, c, a, d);
        @(posedge clk); #1;
        // Garbage on the request bus while busy must be ignored.
        drive(sel, 1'b0, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? rsp_valid_3 : rsp_valid_1) && lat < 50);
        check({name, " latency"}, 32'(lat), 32'(el));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rsp_ready_1 = 1'b1;
        rsp_ready_3 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("reset req_ready",   32'(req_ready_1), 32'd1);
        check("reset rsp_valid",   32'(rsp_valid_1), 32'd0);
        check("reset mem_dmwr",    32'(mem_dmwr_1), 32'd0);
        check("reset mem_dmctrl",  32'(mem_dmctrl_1), 32'd2);
        check("reset mem_address", mem_address_1, 32'd0);
        check("reset mem_datawr",  mem_datawr_1, 32'd0);
        check("reset rsp_rdata",   rsp_rdata_1, 32'd0);
        check("reset rsp_fault",   32'(rsp_fault_1), 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00, 2, "store W 0x10");
        check("dmwr after store W", 32'(dmwr_cnt_1), 32'd1);
        issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00, 2, "load W 0x10");
        check("dmwr after load W", 32'(dmwr_cnt_1), 32'd1);
        issue(1'b0, 1'b1, 3'b000, 32'h21, 32'h1234_5680, 32'h0, 2'b00, 2, "store B 0x21");
        check("dmwr after store B", 32'(dmwr_cnt_1), 32'd2);
        issue(1'b0, 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFF_FF80, 2'b00, 2, "load B 0x21");
        issue(1'b0, 1'b0, 3'b100, 32'h21, 32'h0, 32'h0000_0080, 2'b00, 2, "load BU 0x21");

        issue(1'b0, 1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 2'b01, 1, "load H 0x03");
        issue(1'b0, 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 2'b01, 1, "load W 0x06");
        issue(1'b0, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 2'b11, 1, "ctrl 011");
        issue(1'b0, 1'b1, 3'b001, 32'h01, 32'hFFFF, 32'h0, 2'b01, 1, "store H 0x01");
        check("dmwr after faults", 32'(dmwr_cnt_1), 32'd2);

        issue(1'b0, 1'b1, 3'b010, 32'hFFC, 32'h1122_3344, 32'h0, 2'b00, 2, "store W 0xFFC");
        issue(1'b0, 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h1122_3344, 2'b00, 2, "load W 0xFFC");
        issue(1'b0, 1'b0, 3'b010, 32'hFFD, 32'h0, 32'h0, 2'b01, 1, "load W 0xFFD");
        issue(1'b0, 1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 2'b10, 1, "load B 0x1000");
        issue(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'b10, 1, "load W 0xFFFFFFFC");
        issue(1'b0, 1'b0, 3'b101, 32'hFFE, 32'h0, 32'h0000_1122, 2'b00, 2, "load HU 0xFFE");
        check("dmwr dut1 total", 32'(dmwr_cnt_1), 32'd3);

        // Latency-3 instance: a store, then a load held by writeback back-pressure.
        issue(1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h0, 2'b00, 4, "L3 store W 0x40");
        check("L3 dmwr single pulse", 32'(dmwr_cnt_3), 32'd1);
        @(posedge clk); #1;
        rsp_ready_3 = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE_F00D, 2'b00, 4, "L3 load W 0x40");
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h44, 32'h0BAD_0BAD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("L3 hold rsp_valid", 32'(rsp_valid_3), 32'd1);
            check("L3 hold rsp_rdata", rsp_rdata_3, 32'hCAFE_F00D);
            check("L3 hold rsp_fault", 32'(rsp_fault_3), 32'd0);
            check("L3 hold req_ready", 32'(req_ready_3), 32'd0);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        rsp_ready_3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("L3 idle req_ready", 32'(req_ready_3), 32'd1);
        check("L3 idle rsp_valid", 32'(rsp_valid_3), 32'd0);
        check("L3 busy store ignored", 32'(dmwr_cnt_3), 32'd1);

        // Reset in the middle of a store window.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h50, 32'h5555_5555);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #2;
        check("abort dmwr before reset", 32'(mem_dmwr_3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort dmwr at reset", 32'(mem_dmwr_3), 32'd0);
        check("abort req_ready", 32'(req_ready_3), 32'd1);
        check("abort rsp_valid", 32'(rsp_valid_3), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort no rsp", 32'(rsp_valid_3), 32'd0);
        end
        check("abort dmwr count", 32'(dmwr_cnt_3), 32'd1);

        check("q1 drained", 32'(q1.size()), 32'd0);
        check("q3 drained", 32'(q3.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
